ahb_lite_sram_slave: RTL

Parametrised AHB-Lite slave backed by a byte-addressable register array, with programmable wait states and a two-cycle ERROR response. It is the first synthesisable target for the AHB-Lite verification environment and drives the same signal set the interface bundle carries (HRDATA, HREADYOUT, HRESP). It generalises width, depth and timing, and adds protocol error checking.

---
 rtl/ahb_lite_sram_slave.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a byte-addressable word array. OKAY transfers stall
// for WAIT_STATES cycles; out-of-range, oversized or misaligned transfers get a
// two-cycle ERROR response and never touch memory.
module ahb_lite_sram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(Lanes);
  localparam int unsigned AddrBits = $clog2(MEM_BYTES);
  localparam int unsigned Words    = MEM_BYTES / Lanes;
  localparam int unsigned WordBits = (AddrBits > LaneBits) ? AddrBits - LaneBits : 1;
  localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH + 1)'(MEM_BYTES);
  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;

  logic [DATA_WIDTH-1:0] mem_q [Words];

  logic                  accept;
  logic                  misalign;
  logic                  acc_err;
  logic                  commit;
  logic [LaneBits-1:0]   lane;
  logic [WordBits-1:0]   word_idx;
  logic [Lanes-1:0]      be;
  logic                  unused_inputs;

  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign lane     = addr_q[LaneBits-1:0];
  assign word_idx = WordBits'(addr_q >> LaneBits);

  // Address-phase protocol checks; sizes above the bus width are caught by the size term
  always_comb begin
    misalign = 1'b0;
    for (int unsigned i = 0; i < LaneBits; i++) begin
      if (i < 32'(HSIZE)) misalign = misalign | HADDR[i];
    end
    acc_err = ({1'b0, HADDR} >= MemLimit) | (HSIZE > 3'(LaneBits)) | misalign;
  end

  // State register and latched address-phase controls
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Next state: a new transfer is taken only in a cycle where the current one completes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      StWait:  if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      StErr1:  state_d = StErr2;
      default: ;
    endcase
    if (HREADYOUT) begin
      if (accept) begin
        addr_d  = HADDR[AddrBits-1:0];
        write_d = HWRITE;
        size_d  = HSIZE;
        if (acc_err) begin
          state_d = StErr1;
        end else begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Outputs decoded from the data-phase state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      StWait: begin
        HREADYOUT = (cnt_q == 4'd0);
        if (!write_q) HRDATA = mem_q[word_idx];
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2:  HRESP = 1'b1;
      default: ;
    endcase
  end

  assign commit = (state_q == StWait) && (cnt_q == 4'd0) && write_q;

  // Little-endian byte lanes covered by an aligned transfer of 2^size bytes
  always_comb begin
    be = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      be[i] = ((i >> size_q) == (32'(lane) >> size_q));
    end
  end

  // Memory array (not reset); writes land on the edge that ends an OKAY data phase
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule
